// File: rtl/spi_flash_id_responder.sv
// spi_flash_id_responder
// SPI mode-0 target that emulates the READ-ID path of a serial NOR flash.
// It receives one command byte. For 0x9F, and for 0x9E when ALT_ID_EN is set,
// it answers with the 3-byte JEDEC ID, repeated for as long as cs stays low.
// Every SPI pin is oversampled in the clk12MHz domain. No logic runs on sck.
//
// Ports:
//   clk12MHz     system clock (sole clock)
//   rst          asynchronous active-low reset
//   cs           chip select, active low
//   sck          SPI clock, idles low
//   sdi          initiator-to-target data
//   sdo          target-to-initiator data
//   sdo_oe       high while sdo is driven; tri-state at the top level when low
//   cmd_byte     last fully received command byte
//   cmd_strobe   one-cycle pulse when a command byte completes
//   debug_states current FSM state (0 idle, 1 cmd, 2 id_out, 3 ignore)

module spi_flash_id_responder #(
    parameter logic [7:0] JEDEC_MFR   = 8'hEF,
    parameter logic [7:0] JEDEC_TYPE  = 8'h40,
    parameter logic [7:0] JEDEC_CAP   = 8'h18,
    parameter bit         ALT_ID_EN   = 1'b1,
    parameter int         SYNC_STAGES = 2      // 2..3
) (
    input  logic       clk12MHz,
    input  logic       rst,
    input  logic       cs,
    input  logic       sck,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] cmd_byte,
    output logic       cmd_strobe,
    output logic [1:0] debug_states
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CMD    = 2'd1;
    localparam logic [1:0] ID_OUT = 2'd2;
    localparam logic [1:0] IGNORE = 2'd3;

    // Synchronisers. cs resets to its inactive (high) level, so reset does
    // not look like a cs edge.
    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, sdi_sync_q;
    logic                   cs_prev_q, sck_prev_q;

    always_ff @(posedge clk12MHz or negedge rst) begin
        if (!rst) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    logic cs_s, sck_s, sdi_s;
    logic cs_rise, cs_fall, sck_rise, sck_fall;

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;

    // Protocol state
    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;     // counts up in CMD, down in ID_OUT
    logic [1:0] byte_idx_q, byte_idx_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] cmd_byte_q, cmd_byte_d;
    logic       cmd_strobe_q, cmd_strobe_d;
    logic       sdo_q, sdo_d;

    logic [7:0] id_byte;
    logic [7:0] rx_byte;
    logic       is_read_id;

    always_comb begin
        unique case (byte_idx_q)
            2'd0:    id_byte = JEDEC_MFR;
            2'd1:    id_byte = JEDEC_TYPE;
            default: id_byte = JEDEC_CAP;
        endcase
    end

    assign rx_byte    = {shift_q, sdi_s};
    assign is_read_id = (rx_byte == 8'h9F) || (ALT_ID_EN && (rx_byte == 8'h9E));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        cmd_byte_d   = cmd_byte_q;
        cmd_strobe_d = 1'b0;
        sdo_d        = sdo_q;

        if (cs_rise) begin
            // Deselect wins over any sck edge in the same cycle. A partial
            // command is dropped without a strobe.
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            byte_idx_d = 2'd0;
            shift_d    = 7'd0;
            sdo_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = 3'd0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            cmd_byte_d   = rx_byte;
                            cmd_strobe_d = 1'b1;
                            if (is_read_id) begin
                                state_d    = ID_OUT;
                                byte_idx_d = 2'd0;
                                bit_cnt_d  = 3'd7;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ID_OUT: begin
                    // Drive on the falling edge so the initiator samples on
                    // the following rising edge.
                    if (sck_fall) begin
                        sdo_d     = id_byte[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (bit_cnt_q == 3'd0) begin
                            byte_idx_d = (byte_idx_q == 2'd2) ? 2'd0 : byte_idx_q + 2'd1;
                        end
                    end
                end
                default: begin
                    // IGNORE: wait for cs to rise
                end
            endcase
        end
    end

    always_ff @(posedge clk12MHz or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            byte_idx_q   <= 2'd0;
            shift_q      <= 7'd0;
            cmd_byte_q   <= 8'h00;
            cmd_strobe_q <= 1'b0;
            sdo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            cmd_byte_q   <= cmd_byte_d;
            cmd_strobe_q <= cmd_strobe_d;
            sdo_q        <= sdo_d;
        end
    end

    assign sdo          = sdo_q;
    assign sdo_oe       = (state_q == ID_OUT);
    assign cmd_byte     = cmd_byte_q;
    assign cmd_strobe   = cmd_strobe_q;
    assign debug_states = state_q;

endmodule

// File: tb/tb_spi_flash_id_responder.sv
`timescale 1ns/1ps
module tb_spi_flash_id_responder;

    localparam int HALF = 6;   // sck half-period in clk cycles

    logic clk12MHz = 1'b0;
    logic rst = 1'b0;
    logic cs = 1'b1;
    logic sck = 1'b0;
    logic sdi = 1'b0;

    logic       sdo_a, sdo_oe_a, cmd_strobe_a;
    logic [7:0] cmd_byte_a;
    logic [1:0] states_a;
    logic       sdo_b, sdo_oe_b, cmd_strobe_b;
    logic [7:0] cmd_byte_b;
    logic [1:0] states_b;

    int errors = 0;
    int checks = 0;
    int strobe_a = 0;
    int strobe_b = 0;
    int oe_a_cnt = 0;
    int oe_b_cnt = 0;

    spi_flash_id_responder #(.ALT_ID_EN(1'b1)) dut_a (
        .clk12MHz(clk12MHz), .rst(rst), .cs(cs), .sck(sck), .sdi(sdi),
        .sdo(sdo_a), .sdo_oe(sdo_oe_a), .cmd_byte(cmd_byte_a),
        .cmd_strobe(cmd_strobe_a), .debug_states(states_a)
    );

    spi_flash_id_responder #(.ALT_ID_EN(1'b0)) dut_b (
        .clk12MHz(clk12MHz), .rst(rst), .cs(cs), .sck(sck), .sdi(sdi),
        .sdo(sdo_b), .sdo_oe(sdo_oe_b), .cmd_byte(cmd_byte_b),
        .cmd_strobe(cmd_strobe_b), .debug_states(states_b)
    );

    always #5 clk12MHz = ~clk12MHz;

    always @(posedge clk12MHz) begin
        if (cmd_strobe_a) strobe_a++;
        if (cmd_strobe_b) strobe_b++;
        if (sdo_oe_a) oe_a_cnt++;
        if (sdo_oe_b) oe_b_cnt++;
    end

    // One mode-0 bit: sdi set in the low phase, sdo/sdo_oe sampled as sck rises.
    task automatic sck_bit(input logic b, output logic s, output logic oe);
        sdi = b;
        repeat (HALF) @(negedge clk12MHz);
        s  = sdo_a;
        oe = sdo_oe_a;
        sck = 1'b1;
        repeat (HALF) @(negedge clk12MHz);
        sck = 1'b0;
    endtask

    // Select, clock n bits (command first), leave cs low.
    task automatic xfer(input logic [7:0] cmd, input int n,
                        output logic [47:0] rx, output int oe_bad);
        logic s, oe, b;
        rx = '0;
        oe_bad = 0;
        cs = 1'b0;
        repeat (HALF) @(negedge clk12MHz);
        for (int i = 0; i < n; i++) begin
            b = (i < 8) ? cmd[7-i] : 1'b0;
            sck_bit(b, s, oe);
            if (i >= 8) begin
                rx = {rx[46:0], s};
                if (oe !== 1'b1) oe_bad++;
            end else if (oe !== 1'b0) begin
                oe_bad++;
            end
        end
        repeat (HALF) @(negedge clk12MHz);
    endtask

    task automatic deselect();
        cs = 1'b1;
        repeat (HALF) @(negedge clk12MHz);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk12MHz);
        checks++; if (sdo_a !== 1'b0) begin errors++; $display("FAIL reset_sdo got %b want 0", sdo_a); end
        checks++; if (sdo_oe_a !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", sdo_oe_a); end
        checks++; if (states_a !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", states_a); end
        checks++; if (cmd_byte_a !== 8'h00) begin errors++; $display("FAIL reset_cmd got %h want 00", cmd_byte_a); end
        checks++; if (cmd_strobe_a !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", cmd_strobe_a); end
        rst = 1'b1;
        repeat (HALF) @(negedge clk12MHz);
        checks++; if (states_a !== 2'd0) begin errors++; $display("FAIL post_reset_state got %0d want 0", states_a); end
    endtask

    task automatic test_read_id();
        logic [47:0] rx;
        int oe_bad, s0;
        s0 = strobe_a;
        xfer(8'h9F, 32, rx, oe_bad);
        checks++; if (strobe_a - s0 !== 1) begin errors++; $display("FAIL rid_strobes got %0d want 1", strobe_a - s0); end
        checks++; if (cmd_byte_a !== 8'h9F) begin errors++; $display("FAIL rid_cmd got %h want 9f", cmd_byte_a); end
        checks++; if (rx[23:0] !== 24'hEF4018) begin errors++; $display("FAIL rid_data got %h want ef4018", rx[23:0]); end
        checks++; if (oe_bad !== 0) begin errors++; $display("FAIL rid_oe bad samples %0d want 0", oe_bad); end
        checks++; if (states_a !== 2'd2) begin errors++; $display("FAIL rid_state got %0d want 2", states_a); end
        deselect();
        checks++; if (states_a !== 2'd0) begin errors++; $display("FAIL rid_idle got %0d want 0", states_a); end
        checks++; if (sdo_oe_a !== 1'b0) begin errors++; $display("FAIL rid_oe_off got %b want 0", sdo_oe_a); end
        checks++; if (sdo_a !== 1'b0) begin errors++; $display("FAIL rid_sdo_off got %b want 0", sdo_a); end
    endtask

    task automatic test_wrap();
        logic [47:0] rx;
        int oe_bad;
        xfer(8'h9F, 56, rx, oe_bad);
        checks++; if (rx !== 48'hEF4018EF4018) begin errors++; $display("FAIL wrap_data got %h want ef4018ef4018", rx); end
        checks++; if (oe_bad !== 0) begin errors++; $display("FAIL wrap_oe bad samples %0d want 0", oe_bad); end
        deselect();
    endtask

    task automatic test_alt_id();
        logic [47:0] rx;
        int oe_bad, sb, ob;
        sb = strobe_b;
        ob = oe_b_cnt;
        xfer(8'h9E, 32, rx, oe_bad);
        checks++; if (rx[23:0] !== 24'hEF4018) begin errors++; $display("FAIL alt_data got %h want ef4018", rx[23:0]); end
        checks++; if (states_a !== 2'd2) begin errors++; $display("FAIL alt_state_a got %0d want 2", states_a); end
        checks++; if (states_b !== 2'd3) begin errors++; $display("FAIL alt_state_b got %0d want 3", states_b); end
        checks++; if (oe_b_cnt - ob !== 0) begin errors++; $display("FAIL alt_oe_b got %0d cycles want 0", oe_b_cnt - ob); end
        checks++; if (cmd_byte_b !== 8'h9E) begin errors++; $display("FAIL alt_cmd_b got %h want 9e", cmd_byte_b); end
        checks++; if (strobe_b - sb !== 1) begin errors++; $display("FAIL alt_strobe_b got %0d want 1", strobe_b - sb); end
        checks++; if (sdo_b !== 1'b0) begin errors++; $display("FAIL alt_sdo_b got %b want 0", sdo_b); end
        deselect();
    endtask

    task automatic test_other_cmd();
        logic [47:0] rx;
        int oe_bad, s0, o0;
        s0 = strobe_a;
        o0 = oe_a_cnt;
        xfer(8'h05, 24, rx, oe_bad);
        checks++; if (strobe_a - s0 !== 1) begin errors++; $display("FAIL oth_strobes got %0d want 1", strobe_a - s0); end
        checks++; if (cmd_byte_a !== 8'h05) begin errors++; $display("FAIL oth_cmd got %h want 05", cmd_byte_a); end
        checks++; if (oe_a_cnt - o0 !== 0) begin errors++; $display("FAIL oth_oe got %0d cycles want 0", oe_a_cnt - o0); end
        checks++; if (states_a !== 2'd3) begin errors++; $display("FAIL oth_state got %0d want 3", states_a); end
        deselect();
        checks++; if (states_a !== 2'd0) begin errors++; $display("FAIL oth_idle got %0d want 0", states_a); end
    endtask

    task automatic test_partial();
        logic [47:0] rx;
        logic [7:0] part;
        logic s, oe;
        int oe_bad, s0;
        part = 8'h9F;
        s0 = strobe_a;
        cs = 1'b0;
        repeat (HALF) @(negedge clk12MHz);
        for (int i = 0; i < 5; i++) sck_bit(part[7-i], s, oe);
        repeat (HALF) @(negedge clk12MHz);
        deselect();
        checks++; if (strobe_a - s0 !== 0) begin errors++; $display("FAIL part_strobe got %0d want 0", strobe_a - s0); end
        checks++; if (cmd_byte_a !== 8'h05) begin errors++; $display("FAIL part_cmd got %h want 05", cmd_byte_a); end
        checks++; if (states_a !== 2'd0) begin errors++; $display("FAIL part_idle got %0d want 0", states_a); end
        s0 = strobe_a;
        xfer(8'h9F, 32, rx, oe_bad);
        checks++; if (rx[23:0] !== 24'hEF4018) begin errors++; $display("FAIL part_data got %h want ef4018", rx[23:0]); end
        checks++; if (strobe_a - s0 !== 1) begin errors++; $display("FAIL part_strobe2 got %0d want 1", strobe_a - s0); end
        deselect();
    endtask

    task automatic test_rst_mid();
        logic [47:0] rx;
        logic [7:0] c;
        logic s, oe;
        int oe_bad;
        c = 8'h9F;
        cs = 1'b0;
        repeat (HALF) @(negedge clk12MHz);
        // 8 command bits + 9 ID bits; the 18th rising edge reads 0x40 bit 6
        for (int i = 0; i < 17; i++) sck_bit((i < 8) ? c[7-i] : 1'b0, s, oe);
        sdi = 1'b0;
        repeat (HALF) @(negedge clk12MHz);
        checks++; if (sdo_a !== 1'b1) begin errors++; $display("FAIL mid_sdo_pre got %b want 1", sdo_a); end
        sck = 1'b1;
        repeat (2) @(negedge clk12MHz);
        rst = 1'b0;
        #1;
        checks++; if (sdo_a !== 1'b0) begin errors++; $display("FAIL mid_rst_sdo got %b want 0", sdo_a); end
        checks++; if (sdo_oe_a !== 1'b0) begin errors++; $display("FAIL mid_rst_oe got %b want 0", sdo_oe_a); end
        checks++; if (states_a !== 2'd0) begin errors++; $display("FAIL mid_rst_state got %0d want 0", states_a); end
        checks++; if (cmd_byte_a !== 8'h00) begin errors++; $display("FAIL mid_rst_cmd got %h want 00", cmd_byte_a); end
        sck = 1'b0;
        cs = 1'b1;
        repeat (HALF) @(negedge clk12MHz);
        rst = 1'b1;
        repeat (HALF) @(negedge clk12MHz);
        xfer(8'h9F, 32, rx, oe_bad);
        checks++; if (rx[23:0] !== 24'hEF4018) begin errors++; $display("FAIL mid_after_data got %h want ef4018", rx[23:0]); end
        checks++; if (oe_bad !== 0) begin errors++; $display("FAIL mid_after_oe bad samples %0d want 0", oe_bad); end
        deselect();
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_wrap();
        test_alt_id();
        test_other_cmd();
        test_partial();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a task never returns.
    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
